pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_STAGES, 5, pipeline register count including PC; legal range 4..8.
- LAT_W, 2, width of the result-latency field and of each scoreboard counter.
- CNT_W, 32, width of the performance counters.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock.
- reset_n, in, 1, asynchronous, active-low reset.
- id_valid, in, 1, the decode slot holds a real instruction.
- id_rs1 / id_rs2, in, 5 each, decode source register ids.
- id_rs1_used / id_rs2_used, in, 1 each, the source is actually read.
- id_rd, in, 5, decode destination register.
- id_lat, in, LAT_W, number of cycles the result is not forwardable; 0 means forwardable next cycle, load = 1.
- id_wr, in, 1, the instruction writes id_rd.
- branch_flush, in, 1, EX-stage mispredict redirect.
- imem_busy, in, 1, fetch response not yet returned.
- dmem_busy, in, 1, memory stage waiting on data memory.
- stall, out, NUM_STAGES, per-register hold; index 0 = PC, 1 = IF/ID, 2 = ID/EX, NUM_STAGES-1 = last register.
- flush, out, NUM_STAGES, per-register bubble insert with the same indexing.
- drop_fetch, out, 1, discard the next returning imem response.
- hazard_o, out, 1, raw scoreboard hazard.
- perf_stall_cyc / perf_flush_cnt / perf_hazard_cnt, out, CNT_W each, saturating event counters.

Function
REQ-003 Scoreboard: one LAT_W counter per register x1..x31; x0 is never tracked.
REQ-004 hazard_o = id_valid & ((id_rs1_used & id_rs1 != 0 & cnt[id_rs1] != 0) | (id_rs2_used & id_rs2 != 0 & cnt[id_rs2] != 0)).
REQ-005 An issue occurs when id_valid & id_wr & id_rd != 0 & !stall[2] & !flush[2].
REQ-006 On issue, cnt[id_rd] loads id_lat, overwriting any nonzero value.
REQ-007 In every non-frozen cycle, each nonzero counter decrements by 1.
REQ-008 When a counter is both loaded and decremented in the same cycle, the load wins.
REQ-009 Control priority, highest first, is: freeze, redirect, hazard, fetch-wait.
- Freeze (dmem_busy): stall[0..NUM_STAGES-2] = 1 and flush[NUM_STAGES-1] = 1. Scoreboard and FSM transitions hold.
- Redirect (branch_flush & !dmem_busy): flush[0..2] = 1, no stalls, and the scoreboard ignores the killed decode. Redirect overrides hazard.
- Hazard: stall[0..1] = 1 and flush[2] = 1.
- Fetch-wait (imem_busy): stall[0] = 1 and flush[1] = 1.
REQ-010 The FSM has states RUN and DROP.
- RUN -> DROP when a redirect occurs while imem_busy = 1.
- DROP -> RUN on the first cycle imem_busy = 0.
- drop_fetch = 1 in DROP.
- A redirect arriving while already in DROP stays in DROP.
REQ-011 Performance counters:
- perf_stall_cyc increments on any cycle with stall != 0.
- perf_flush_cnt increments on each redirect.
- perf_hazard_cnt increments on each cycle hazard wins priority.
- All three saturate at all-ones.
REQ-012 stall and flush are combinational from the inputs and state, with no added latency; scoreboard and FSM update on the rising clk edge.

Reset
REQ-013 While reset_n = 0:
- Counters, FSM and performance counters are cleared asynchronously to 0 / RUN.
- stall = 0, flush = all-ones, drop_fetch = 0.
REQ-014 Reset asserted mid-DROP or with pending counters clears all state; the first cycle after release behaves as RUN with an empty scoreboard.

Structure
REQ-015 The shared package holds:
- parameter defaults;
- the FSM state enum (ctrl_state_t);
- stage-index constants IDX_PC = 0, IDX_IFID = 1, IDX_IDEX = 2.
REQ-016 One sub-module, pc_scoreboard, holds the 31 counters, issue and decrement logic, and the hazard compare; everything else stays in pipeline_ctrl.

Verification
REQ-017 Load-use: issue id_rd = 5, id_lat = 1; next cycle id_rs1 = 5 used -> hazard one cycle (stall = 00011, flush = 00100), then clear.
REQ-018 Latency 3: issue id_rd = 7, id_lat = 3; dependent waits -> exactly 3 hazard cycles and perf_hazard_cnt = 3.
REQ-019 Redirect beats hazard: hazard and branch_flush same cycle -> flush = 00111, stall = 0, cnt[rd] of the killed decode not loaded.
REQ-020 Redirect during imem_busy: -> state DROP with drop_fetch = 1, held until imem_busy falls, then RUN.
REQ-021 Freeze: dmem_busy for 4 cycles with cnt[3] = 2 -> stall = 01111 and flush = 10000 each cycle, cnt[3] still 2 afterward.
REQ-022 Reset mid-DROP with cnt[9] = 2 -> after release drop_fetch = 0, no hazard on x9, all performance counters 0; also check x0 sources never hazard.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
// Holds parameter defaults, the fetch-drop FSM state type and the
// stage-register index constants used by the stall/flush vectors.
package pipeline_ctrl_pkg;

  localparam int NUM_STAGES_DEF = 5;
  localparam int LAT_W_DEF      = 2;
  localparam int CNT_W_DEF      = 32;

  // Stage-register indices into the stall/flush vectors.
  localparam int IDX_PC   = 0;
  localparam int IDX_IFID = 1;
  localparam int IDX_IDEX = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// pc_scoreboard: per-register result-latency tracker for x1..x31.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   id_valid              decode slot holds a real instruction
//   id_rs1/id_rs2         decode source register ids
//   id_rs1_used/_rs2_used source is actually read
//   issue_i               decode instruction issues this cycle
//   id_rd, id_lat         destination and its not-forwardable latency
//   hold_i                pipeline frozen: counters keep their value
//   hazard_o              a read source still has a pending result
module pc_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             issue_i,
  input  logic [4:0]       id_rd,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             hold_i,
  output logic             hazard_o
);

  // Entry 0 exists only so the lookup can be indexed directly; it is
  // forced to zero so x0 never reports a pending result.
  logic [LAT_W-1:0] cnt_q [0:31];
  logic [LAT_W-1:0] cnt_d [0:31];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!hold_i && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - LAT_W'(1);
      // A fresh issue overwrites whatever is still counting down.
      if (issue_i && (id_rd == 5'(i))) cnt_d[i] = id_lat;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  logic rs1_hit, rs2_hit;
  assign rs1_hit  = id_rs1_used && (id_rs1 != 5'd0) && (cnt_q[id_rs1] != '0);
  assign rs2_hit  = id_rs2_used && (id_rs2 != 5'd0) && (cnt_q[id_rs2] != '0);
  assign hazard_o = id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush arbiter for an in-order pipeline.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   id_*                     decode-slot instruction fields
//   branch_flush             EX-stage mispredict redirect
//   imem_busy / dmem_busy    fetch / data memory still outstanding
//   stall, flush             per-register hold / bubble (0 = PC)
//   drop_fetch               discard the next returning imem response
//   hazard_o                 raw scoreboard hazard
//   perf_*                   saturating event counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int LAT_W      = LAT_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            id_rd,
  input  logic [LAT_W-1:0]      id_lat,
  input  logic                  id_wr,
  input  logic                  branch_flush,
  input  logic                  imem_busy,
  input  logic                  dmem_busy,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  drop_fetch,
  output logic                  hazard_o,
  output logic [CNT_W-1:0]      perf_stall_cyc,
  output logic [CNT_W-1:0]      perf_flush_cnt,
  output logic [CNT_W-1:0]      perf_hazard_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic freeze, redirect, hazard_win, issue, hazard;

  assign freeze     = dmem_busy;
  assign redirect   = branch_flush && !dmem_busy;
  assign hazard_win = hazard && !freeze && !redirect;
  assign hazard_o   = hazard;

  // Priority: freeze > redirect > hazard > fetch-wait.
  always_comb begin
    stall = '0;
    flush = '0;
    if (!reset_n) begin
      flush = '1;
    end else if (freeze) begin
      for (int i = 0; i < NUM_STAGES - 1; i++) stall[i] = 1'b1;
      flush[NUM_STAGES-1] = 1'b1;
    end else if (redirect) begin
      for (int i = IDX_PC; i <= IDX_IDEX; i++) flush[i] = 1'b1;
    end else if (hazard) begin
      stall[IDX_PC]   = 1'b1;
      stall[IDX_IFID] = 1'b1;
      flush[IDX_IDEX] = 1'b1;
    end else if (imem_busy) begin
      stall[IDX_PC]   = 1'b1;
      flush[IDX_IFID] = 1'b1;
    end
  end

  // A decode that is stalled or replaced by a bubble never reaches EX,
  // so it must not claim its destination in the scoreboard.
  assign issue = id_valid && id_wr && (id_rd != 5'd0)
              && !stall[IDX_IDEX] && !flush[IDX_IDEX];

  pc_scoreboard #(.LAT_W(LAT_W)) u_sb (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .issue_i     (issue),
    .id_rd       (id_rd),
    .id_lat      (id_lat),
    .hold_i      (freeze),
    .hazard_o    (hazard)
  );

  // Fetch-drop FSM: a redirect while a fetch is in flight leaves a stale
  // response on its way back, which must be discarded.
  ctrl_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (!freeze) begin
      case (state_q)
        ST_RUN:  if (redirect && imem_busy) state_d = ST_DROP;
        ST_DROP: if (!imem_busy)            state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  assign drop_fetch = reset_n && (state_q == ST_DROP);

  logic [CNT_W-1:0] stall_cyc_q, flush_cnt_q, hazard_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cyc_q  <= '0;
      flush_cnt_q  <= '0;
      hazard_cnt_q <= '0;
    end else begin
      if (|stall)     stall_cyc_q  <= sat_inc(stall_cyc_q);
      if (redirect)   flush_cnt_q  <= sat_inc(flush_cnt_q);
      if (hazard_win) hazard_cnt_q <= sat_inc(hazard_cnt_q);
    end
  end

  assign perf_stall_cyc  = stall_cyc_q;
  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_wr = 1'b0;
  logic [1:0]  id_lat = '0;
  logic        branch_flush = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0;
  logic [4:0]  stall, flush;
  logic        drop_fetch, hazard_o;
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_hazard_cnt;

  pipeline_ctrl #(.NUM_STAGES(5), .LAT_W(2), .CNT_W(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_lat          (id_lat),
    .id_wr           (id_wr),
    .branch_flush    (branch_flush),
    .imem_busy       (imem_busy),
    .dmem_busy       (dmem_busy),
    .stall           (stall),
    .flush           (flush),
    .drop_fetch      (drop_fetch),
    .hazard_o        (hazard_o),
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_hazard_cnt (perf_hazard_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [4:0] st;
    logic [4:0] fl;
    logic       drp;
    logic       hz;
    bit         pc;
    int         ps;
    int         pf;
    int         ph;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_n = 0;
  bit   pchk = 0;
  int   pps = 0, ppf = 0, pph = 0;

  task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cyc%0d %s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  // Monitor: every presented cycle is compared against the oldest expectation.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.tag, "stall", 32'(stall), 32'(e.st));
      chk(e.tag, "flush", 32'(flush), 32'(e.fl));
      chk(e.tag, "drop_fetch", 32'(drop_fetch), 32'(e.drp));
      chk(e.tag, "hazard", 32'(hazard_o), 32'(e.hz));
      if (e.pc) begin
        chk(e.tag, "perf_stall_cyc", perf_stall_cyc, e.ps);
        chk(e.tag, "perf_flush_cnt", perf_flush_cnt, e.pf);
        chk(e.tag, "perf_hazard_cnt", perf_hazard_cnt, e.ph);
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic wr,
                       input logic [4:0] rd, input logic [1:0] lat,
                       input logic bf, input logic ib, input logic db);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_wr = wr; id_rd = rd; id_lat = lat;
    branch_flush = bf; imem_busy = ib; dmem_busy = db;
  endtask

  task automatic perf(input int s, input int f, input int h);
    pchk = 1; pps = s; ppf = f; pph = h;
  endtask

  // Push the expectation for the current cycle, then advance one clock.
  task automatic cyc(input logic [4:0] st, input logic [4:0] fl, input logic drp, input logic hz);
    exp_t e;
    e.tag = cyc_n; e.st = st; e.fl = fl; e.drp = drp; e.hz = hz;
    e.pc = pchk; e.ps = pps; e.pf = ppf; e.ph = pph;
    sbq.push_back(e);
    pchk = 0;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    perf(0, 0, 0); cyc(5'b00000, 5'b11111, 0, 0);
    reset_n = 1'b1;
    perf(0, 0, 0); cyc(5'b00000, 5'b00000, 0, 0);

    // Load-use: x5 latency 1 -> one hazard cycle
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0); cyc(5'b00000, 5'b00000, 0, 0);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); cyc(5'b00011, 5'b00100, 0, 1);
    perf(1, 0, 1);                          cyc(5'b00000, 5'b00000, 0, 0);

    // Latency 3 on x7 read via rs2: three hazard cycles (hazard count 1 -> 4)
    drive(1, 0, 0, 0, 0, 1, 7, 3, 0, 0, 0); cyc(5'b00000, 5'b00000, 0, 0);
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0); cyc(5'b00011, 5'b00100, 0, 1);
    cyc(5'b00011, 5'b00100, 0, 1);
    cyc(5'b00011, 5'b00100, 0, 1);
    perf(4, 0, 4);                          cyc(5'b00000, 5'b00000, 0, 0);

    // Redirect beats hazard; killed decode (x11) must not be tracked
    drive(1, 0, 0, 0, 0, 1, 10, 2, 0, 0, 0); cyc(5'b00000, 5'b00000, 0, 0);
    drive(1, 10, 1, 0, 0, 1, 11, 3, 1, 0, 0); cyc(5'b00000, 5'b00111, 0, 1);
    drive(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    perf(4, 1, 4);                           cyc(5'b00000, 5'b00000, 0, 0);

    // Redirect during imem_busy -> DROP until imem_busy falls
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cyc(5'b00000, 5'b00111, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc(5'b00001, 5'b00010, 1, 0);
    cyc(5'b00001, 5'b00010, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(5'b00000, 5'b00000, 1, 0);
    perf(6, 2, 4);                          cyc(5'b00000, 5'b00000, 0, 0);

    // Freeze for 4 cycles with x3 pending 2; a redirect inside is ignored
    drive(1, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0); cyc(5'b00000, 5'b00000, 0, 0);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1); cyc(5'b01111, 5'b10000, 0, 1);
    cyc(5'b01111, 5'b10000, 0, 1);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1); cyc(5'b01111, 5'b10000, 0, 1);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1); cyc(5'b01111, 5'b10000, 0, 1);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    perf(10, 2, 4);                         cyc(5'b00011, 5'b00100, 0, 1);
    cyc(5'b00011, 5'b00100, 0, 1);
    perf(12, 2, 6);                         cyc(5'b00000, 5'b00000, 0, 0);

    // Reset mid-DROP with x9 pending 2
    drive(1, 0, 0, 0, 0, 1, 9, 3, 0, 0, 0); cyc(5'b00000, 5'b00000, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cyc(5'b00000, 5'b00111, 0, 0);
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    reset_n = 1'b0;
    perf(0, 0, 0);                          cyc(5'b00000, 5'b11111, 0, 0);
    reset_n = 1'b1;
    perf(0, 0, 0);                          cyc(5'b00001, 5'b00010, 0, 0);

    // x0 sources never hazard, x0 destination never tracked
    drive(1, 0, 1, 0, 1, 1, 0, 3, 0, 0, 0); cyc(5'b00000, 5'b00000, 0, 0);
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    perf(1, 0, 0);                          cyc(5'b00000, 5'b00000, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
